// File: rtl/lsfr_pkg.sv
// Shared definitions for the lsfr generator and checker: word width, state
// encoding and the stream recurrence.
package lsfr_pkg;

  localparam int unsigned WORD_W = 32;

  typedef enum logic {
    SEED,
    LOCKED
  } state_e;

  // s0 is the oldest of the three words; returns the word that follows s2 after one more.
  function automatic logic [WORD_W-1:0] lsfr_next(input logic [WORD_W-1:0] s0,
                                                  input logic [WORD_W-1:0] s1,
                                                  input logic [WORD_W-1:0] s2);
    return s2 ^ (s1 << 31) ^ (s0 >> 1);
  endfunction

endpackage

// File: rtl/lsfr_checker.sv
// Stream checker: seeds its history from four received words, then predicts each
// following word and flags mismatches, flywheeling on the prediction.
module lsfr_checker
  import lsfr_pkg::*;
#(
  parameter int unsigned ERR_THRESH = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [31:0]       in_data,
  input  logic              clear,
  output logic              locked,
  output logic              err,
  output logic [5:0]        err_bits,
  output logic [CNT_W-1:0]  err_count
);

  localparam logic [3:0]       MissLimit = 4'(ERR_THRESH);
  localparam logic [CNT_W-1:0] CntMax    = '1;

  function automatic logic [5:0] popcount(input logic [WORD_W-1:0] v);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < WORD_W; i++) begin
      c = c + 6'(v[i]);
    end
    return c;
  endfunction

  state_e            state_q, state_d;
  logic [2:0]        seed_q, seed_d;
  logic [3:0]        miss_q, miss_d;
  logic [WORD_W-1:0] h0_q, h1_q, h2_q, h3_q;
  logic [WORD_W-1:0] h0_d, h1_d, h2_d, h3_d;
  logic              err_q, err_d;
  logic [5:0]        bits_q, bits_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [WORD_W-1:0] predicted;
  logic [WORD_W-1:0] shift_word;
  logic [3:0]        miss_inc;
  logic              mismatch;

  assign predicted = lsfr_next(h0_q, h1_q, h2_q);
  assign mismatch  = in_valid && (state_q == LOCKED) && (in_data != predicted);
  assign miss_inc  = miss_q + 4'd1;

  always_comb begin
    state_d    = state_q;
    seed_d     = seed_q;
    miss_d     = miss_q;
    h0_d       = h0_q;
    h1_d       = h1_q;
    h2_d       = h2_q;
    h3_d       = h3_q;
    err_d      = 1'b0;
    bits_d     = '0;
    shift_word = in_data;

    if (in_valid) begin
      unique case (state_q)
        SEED: begin
          if (seed_q == 3'd3) begin
            state_d = LOCKED;
            seed_d  = 3'd4;
          end else begin
            seed_d = seed_q + 3'd1;
          end
        end
        LOCKED: begin
          if (mismatch) begin
            // Flywheel: keep the history on the predicted sequence.
            shift_word = predicted;
            err_d      = 1'b1;
            bits_d     = popcount(in_data ^ predicted);
            if (miss_inc == MissLimit) begin
              state_d = SEED;
              seed_d  = '0;
              miss_d  = '0;
            end else begin
              miss_d = miss_inc;
            end
          end else begin
            miss_d = '0;
          end
        end
      endcase
      h0_d = h1_q;
      h1_d = h2_q;
      h2_d = h3_q;
      h3_d = shift_word;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (mismatch && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= SEED;
      seed_q  <= '0;
      miss_q  <= '0;
      h0_q    <= '0;
      h1_q    <= '0;
      h2_q    <= '0;
      h3_q    <= '0;
      err_q   <= 1'b0;
      bits_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      seed_q  <= seed_d;
      miss_q  <= miss_d;
      h0_q    <= h0_d;
      h1_q    <= h1_d;
      h2_q    <= h2_d;
      h3_q    <= h3_d;
      err_q   <= err_d;
      bits_q  <= bits_d;
      cnt_q   <= cnt_d;
    end
  end

  assign locked    = (state_q == LOCKED);
  assign err       = err_q;
  assign err_bits  = bits_q;
  assign err_count = cnt_q;

endmodule

// File: tb/tb_lsfr_checker.sv
// Directed bench for lsfr_checker: default instance plus a small-counter,
// high-threshold instance for saturation and clear.
module tb_lsfr_checker;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        clear = 1'b0;

  logic        locked, err;
  logic [5:0]  err_bits;
  logic [15:0] err_count;
  logic        sat_locked, sat_err;
  logic [5:0]  sat_bits;
  logic [3:0]  sat_count;

  int checks = 0;
  int errors = 0;

  logic [31:0] stream [0:63];

  always #5 clock = ~clock;

  lsfr_checker dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .clear     (clear),
    .locked    (locked),
    .err       (err),
    .err_bits  (err_bits),
    .err_count (err_count)
  );

  lsfr_checker #(
    .ERR_THRESH (15),
    .CNT_W      (4)
  ) dut_sat (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .clear     (clear),
    .locked    (sat_locked),
    .err       (sat_err),
    .err_bits  (sat_bits),
    .err_count (sat_count)
  );

  function automatic logic [31:0] ref_next(input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] c);
    return c ^ {b[0], 31'b0} ^ {1'b0, a[31:1]};
  endfunction

  function automatic int ref_pop(input logic [31:0] v);
    int n = 0;
    for (int i = 0; i < 32; i++) n += int'(v[i]);
    return n;
  endfunction

  // Present one word for one clock; outputs are sampled 1 ns after the edge.
  task automatic send(input logic [31:0] w, input logic v, input logic c);
    @(negedge clock);
    in_data  = w;
    in_valid = v;
    clear    = c;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    clear    = 1'b0;
  endtask

  task automatic do_reset(input logic v, input logic [31:0] w);
    @(negedge clock);
    reset    = 1'b1;
    in_valid = v;
    in_data  = w;
    @(posedge clock);
    #1;
    reset    = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    checks++;
    if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked: got %0b expected 0", locked); end
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b expected 0", err); end
    checks++;
    if (err_bits !== 6'd0) begin errors++; $display("FAIL reset_bits: got %0d expected 0", err_bits); end
    checks++;
    if (err_count !== 16'd0) begin
      errors++; $display("FAIL reset_count: got %0d expected 0", err_count);
    end
    checks++;
    if (sat_count !== 4'd0 || sat_locked !== 1'b0) begin
      errors++; $display("FAIL reset_sat: got count %0d locked %0b expected 0 0", sat_count, sat_locked);
    end
  endtask

  task automatic test_clean_lock;
    do_reset(1'b0, 32'h0);
    for (int i = 0; i < 7; i++) begin
      send(stream[i], 1'b1, 1'b0);
      checks++;
      if (err !== 1'b0) begin errors++; $display("FAIL clean_err[%0d]: got %0b expected 0", i, err); end
      checks++;
      if (locked !== (i >= 3)) begin
        errors++; $display("FAIL clean_locked[%0d]: got %0b expected %0b", i, locked, i >= 3);
      end
    end
    checks++;
    if (err_count !== 16'd0) begin
      errors++; $display("FAIL clean_count: got %0d expected 0", err_count);
    end
  endtask

  task automatic test_single_bit_error;
    do_reset(1'b0, 32'h0);
    for (int i = 0; i < 4; i++) send(stream[i], 1'b1, 1'b0);
    send(32'h8000_00B5, 1'b1, 1'b0);
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL sbe_err: got %0b expected 1", err); end
    checks++;
    if (err_bits !== 6'd1) begin errors++; $display("FAIL sbe_bits: got %0d expected 1", err_bits); end
    checks++;
    if (err_count !== 16'd1) begin
      errors++; $display("FAIL sbe_count: got %0d expected 1", err_count);
    end
    for (int i = 5; i < 7; i++) begin
      send(stream[i], 1'b1, 1'b0);
      checks++;
      if (err !== 1'b0 || locked !== 1'b1) begin
        errors++; $display("FAIL sbe_flywheel[%0d]: got err %0b locked %0b expected 0 1", i, err, locked);
      end
    end
    checks++;
    if (err_count !== 16'd1) begin
      errors++; $display("FAIL sbe_count_hold: got %0d expected 1", err_count);
    end
  endtask

  // Continues from test_single_bit_error: next expected word is stream[7].
  task automatic test_lock_loss;
    for (int i = 0; i < 4; i++) begin
      send(32'hFFFF_FFFF, 1'b1, 1'b0);
      checks++;
      if (err !== 1'b1) begin errors++; $display("FAIL loss_err[%0d]: got %0b expected 1", i, err); end
      checks++;
      if (int'(err_bits) != 32 - ref_pop(stream[7+i])) begin
        errors++;
        $display("FAIL loss_bits[%0d]: got %0d expected %0d", i, err_bits, 32 - ref_pop(stream[7+i]));
      end
      checks++;
      if (locked !== (i < 3)) begin
        errors++; $display("FAIL loss_locked[%0d]: got %0b expected %0b", i, locked, i < 3);
      end
      checks++;
      if (err_count !== 16'(2 + i)) begin
        errors++; $display("FAIL loss_count[%0d]: got %0d expected %0d", i, err_count, 2 + i);
      end
    end
    for (int j = 0; j < 6; j++) begin
      send(stream[20+j], 1'b1, 1'b0);
      checks++;
      if (err !== 1'b0 || locked !== (j >= 3)) begin
        errors++;
        $display("FAIL relock[%0d]: got err %0b locked %0b expected 0 %0b", j, err, locked, j >= 3);
      end
    end
  endtask

  task automatic test_reset_mid;
    checks++;
    if (err_count !== 16'd5 || locked !== 1'b1) begin
      errors++; $display("FAIL mid_pre: got count %0d locked %0b expected 5 1", err_count, locked);
    end
    do_reset(1'b1, stream[26]);
    checks++;
    if (locked !== 1'b0 || err_count !== 16'd0 || err !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got locked %0b count %0d err %0b expected 0 0 0", locked, err_count, err);
    end
    for (int j = 0; j < 5; j++) begin
      send(stream[40+j], 1'b1, 1'b0);
      checks++;
      if (err !== 1'b0 || locked !== (j >= 3)) begin
        errors++;
        $display("FAIL mid_relock[%0d]: got err %0b locked %0b expected 0 %0b", j, err, locked, j >= 3);
      end
    end
  endtask

  task automatic test_gaps;
    do_reset(1'b0, 32'h0);
    for (int i = 0; i < 7; i++) begin
      int gaps;
      gaps = $urandom_range(0, 3);
      for (int g = 0; g < gaps; g++) begin
        send($urandom, 1'b0, 1'b0);
        checks++;
        if (err !== 1'b0 || locked !== (i >= 4)) begin
          errors++;
          $display("FAIL gap_idle[%0d]: got err %0b locked %0b expected 0 %0b", i, err, locked, i >= 4);
        end
      end
      send(stream[i], 1'b1, 1'b0);
      checks++;
      if (err !== 1'b0 || locked !== (i >= 3)) begin
        errors++;
        $display("FAIL gap_word[%0d]: got err %0b locked %0b expected 0 %0b", i, err, locked, i >= 3);
      end
    end
    checks++;
    if (err_count !== 16'd0) begin
      errors++; $display("FAIL gap_count: got %0d expected 0", err_count);
    end
  endtask

  task automatic test_saturation_clear;
    do_reset(1'b0, 32'h0);
    for (int i = 0; i < 4; i++) send(stream[i], 1'b1, 1'b0);
    checks++;
    if (sat_locked !== 1'b1) begin errors++; $display("FAIL sat_lock: got %0b expected 1", sat_locked); end
    for (int i = 0; i < 20; i++) begin
      send(stream[4+2*i] ^ 32'h1, 1'b1, 1'b0);
      checks++;
      if (sat_err !== 1'b1 || sat_bits !== 6'd1) begin
        errors++; $display("FAIL sat_err[%0d]: got err %0b bits %0d expected 1 1", i, sat_err, sat_bits);
      end
      checks++;
      if (int'(sat_count) != ((i + 1 > 15) ? 15 : i + 1)) begin
        errors++;
        $display("FAIL sat_count[%0d]: got %0d expected %0d", i, sat_count, (i + 1 > 15) ? 15 : i + 1);
      end
      send(stream[5+2*i], 1'b1, 1'b0);
      checks++;
      if (sat_err !== 1'b0 || sat_locked !== 1'b1) begin
        errors++;
        $display("FAIL sat_match[%0d]: got err %0b locked %0b expected 0 1", i, sat_err, sat_locked);
      end
    end
    send(stream[44] ^ 32'h10, 1'b1, 1'b1);
    checks++;
    if (sat_err !== 1'b1 || sat_count !== 4'd0) begin
      errors++;
      $display("FAIL clear_mismatch: got err %0b count %0d expected 1 0", sat_err, sat_count);
    end
    send(stream[45], 1'b1, 1'b0);
    checks++;
    if (sat_err !== 1'b0 || sat_count !== 4'd0) begin
      errors++; $display("FAIL clear_after: got err %0b count %0d expected 0 0", sat_err, sat_count);
    end
  endtask

  initial begin
    stream[0] = 32'd364;
    stream[1] = 32'd1;
    stream[2] = 32'd2;
    stream[3] = 32'd3;
    stream[4] = 32'h8000_00B4;
    stream[5] = 32'd3;
    stream[6] = 32'h0000_00B5;
    for (int k = 7; k < 64; k++) stream[k] = ref_next(stream[k-4], stream[k-3], stream[k-2]);

    test_reset();
    test_clean_lock();
    test_single_bit_error();
    test_lock_loss();
    test_reset_mid();
    test_gaps();
    test_saturation_clear();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsfr_checker.md
LSFR_CHECKER -- requirements
Module: lsfr_checker

Interface
REQ-001 Parameter ERR_THRESH, default 4: number of consecutive mismatches in LOCKED that forces loss of lock (range 1..15).
REQ-002 Parameter CNT_W, default 16: width of the error counter.
REQ-003 clock  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  in_data carries a stream word this cycle.
REQ-006 in_data  input  32  received word from the lsfr generator output o0.
REQ-007 clear  input  1  synchronous clear of err_count; does not affect lock.
REQ-008 locked  output  1  checker is synchronised to the stream.
REQ-009 err  output  1  one-cycle pulse: the previous valid word mismatched its prediction.
REQ-010 err_bits  output  6  popcount of (in_data XOR predicted) for the word flagged by err; 0 when err=0.
REQ-011 err_count  output  CNT_W  saturating count of mismatched words since reset or clear.

Function
REQ-012 The recurrence SHALL be next = s[n+2] ^ (s[n+1] << 31) ^ (s[n] >> 1); all 32-bit, logical shifts, upper bits discarded.
REQ-013 Four 32-bit history registers h0..h3 (h0 oldest) SHALL hold the last four accepted words; prediction = h2 ^ (h1 << 31) ^ (h0 >> 1).
REQ-014 States: SEED, LOCKED. A seed counter 0..4 and a miss counter 0..ERR_THRESH accompany them.
REQ-015 Cycles with in_valid=0 SHALL change no state and produce err=0.
REQ-016 SEED: each valid word shifts into h3 (h0<=h1, h1<=h2, h2<=h3); no comparison, err stays 0.
REQ-017 SEED -> LOCKED on the cycle the 4th valid seed word is accepted; locked=1 from the next cycle.
REQ-018 LOCKED, match: received word shifted into history; miss counter cleared.
REQ-019 LOCKED, mismatch: predicted word (not received) shifted into history (flywheel); err=1 and err_bits registered next cycle; miss counter incremented.
REQ-020 When the miss counter reaches ERR_THRESH, the state SHALL return to SEED on that same edge: seed counter 0, miss counter 0, locked=0 next cycle; that word still counts as an error.
REQ-021 err, err_bits, locked SHALL be registered: one cycle latency from the in_valid cycle.
REQ-022 err_count SHALL increment by 1 per mismatched word and hold at 2^CNT_W-1 without wrap.
REQ-023 clear and a mismatch in the same cycle: clear wins, err_count=0; err pulse still asserted.

Reset
REQ-024 reset=1 SHALL force: state SEED, seed and miss counters 0, h0..h3=0, locked=0, err=0, err_bits=0, err_count=0.
REQ-025 reset mid-stream SHALL discard history; words in the reset cycle are ignored; resynchronisation needs 4 fresh valid words.

Structure
REQ-026 Package lsfr_pkg SHALL hold the state enum (SEED, LOCKED), the 32-bit word width constant, and the recurrence function lsfr_next(s0,s1,s2) shared with lsfr.
REQ-027 No sub-module; popcount implemented as a local function or loop in lsfr_checker.

Verification
REQ-028 Clean lock: after reset drive 364, 1, 2, 3, 0x800000B4, 3, 0x000000B5 -> locked=1 one cycle after 4th word; err never asserted; err_count=0.
REQ-029 Single-bit error: locked stream, send 0x800000B5 instead of 0x800000B4 -> err=1, err_bits=1, err_count=1; following correct words 3, 0xB5 match (flywheel), locked stays 1.
REQ-030 Lock loss: locked stream, ERR_THRESH=4 consecutive words 0xFFFFFFFF -> err pulses 4 times, locked=0 after 4th; next 4 words reseed, then locked=1 again.
REQ-031 Gaps: clean stream with in_valid low on random cycles (up to 3 consecutive) -> identical results to REQ-028.
REQ-032 Saturation and clear: CNT_W=4, 20 isolated mismatches (ERR_THRESH=15) -> err_count holds 15; clear together with a mismatch -> err_count=0, err=1.
REQ-033 Reset mid-operation: reset asserted while LOCKED with err_count=5 -> next cycle locked=0, err_count=0; fresh seed from any stream position relocks after 4 words.
